// File: rtl/pipe_pkg.sv
// Shared constants and state type for the pipe_skid_reg skid buffer.
package pipe_pkg;

    localparam int unsigned DefaultWidth = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/flopenr.sv
// N-bit enabled register with synchronous active-low clear to zero.
module flopenr
    import pipe_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] data_d;
    logic [N-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer: fully registered valid/ready stage with 1 word/cycle throughput.
// Define PIPE_SKID_FLUSH_EN to add a synchronous active-high flush input.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic         clk,
    input  logic         reset,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready
);

    state_e       state_d;
    state_e       state_q;
    logic         main_en;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic         skid_en;
    logic [N-1:0] skid_q;
    logic         in_xfer;
    logic         out_xfer;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Skid word moves up; in_ready is low so nothing new enters.
                if (out_xfer) begin
                    state_d = ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Drop everything but leave the data registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    flopenr #(
        .N(N)
    ) u_main (
        .clk  (clk),
        .reset(reset),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    flopenr #(
        .N(N)
    ) u_skid (
        .clk  (clk),
        .reset(reset),
        .en_i (skid_en),
        .d_i  (in_data),
        .q_o  (skid_q)
    );

endmodule
